// File: rtl/gelu_row_driver.sv
// gelu_row_driver
// Sequencer that moves one row of Q6.10 samples from a source buffer through
// the LUT-based GELU activation unit and into a destination buffer.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   start                           begin one row (accepted only when idle)
//   src_rd_en/addr, src_rd_data     source buffer read port (data sampled one
//                                   clock edge after the read strobe)
//   act_valid, act_x                samples towards the activation unit
//   act_valid_out, act_y, act_oor   results from the activation unit
//   dst_wr_en/addr/data             destination buffer write port
//   busy, done, error, oor_count    status towards the FFN controller
module gelu_row_driver #(
  parameter int DATA_WIDTH = 16,
  parameter int ROW_LEN    = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  src_rd_en,
  output logic [ADDR_WIDTH-1:0] src_rd_addr,
  input  logic [DATA_WIDTH-1:0] src_rd_data,
  output logic                  act_valid,
  output logic [DATA_WIDTH-1:0] act_x,
  input  logic                  act_valid_out,
  input  logic [DATA_WIDTH-1:0] act_y,
  input  logic                  act_oor,
  output logic                  dst_wr_en,
  output logic [ADDR_WIDTH-1:0] dst_wr_addr,
  output logic [DATA_WIDTH-1:0] dst_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   oor_count
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int IW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] ROW_LEN_C = CW'(ROW_LEN);
  localparam logic [CW-1:0] LAST_C    = CW'(ROW_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [IW-1:0] TIMEOUT_C = IW'(TIMEOUT);
  localparam logic [IW-1:0] IDLE_ONE  = IW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]           wr_cnt_q, wr_cnt_d;
  logic [IW-1:0]           idle_q, idle_d;
  logic [CW-1:0]           oor_q, oor_d;
  logic                    err_q, err_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    act_valid_q, act_valid_d;
  logic [DATA_WIDTH-1:0]   act_x_q, act_x_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    result_ok_s;

  // A result is only written while a row is active and still has room.
  assign result_ok_s = act_valid_out
                     && ((state_q == S_ISSUE) || (state_q == S_DRAIN))
                     && (wr_cnt_q < ROW_LEN_C);

  // Next-state computation for the FSM, issue path and collect path.
  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    idle_d      = idle_q;
    oor_d       = oor_q;
    err_d       = err_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    // Source data is sampled on the edge after the read strobe, so the
    // sample and its valid flag leave together one cycle after src_rd_en.
    act_valid_d = rd_en_q;
    act_x_d     = rd_en_q ? src_rd_data : act_x_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Address 0 goes out on the acceptance edge itself.
          state_d   = (ROW_LEN == 1) ? S_DRAIN : S_ISSUE;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          rd_cnt_d  = CNT_ONE;
          wr_cnt_d  = '0;
          oor_d     = '0;
          err_d     = 1'b0;
          idle_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        rd_en_d   = 1'b1;
        rd_addr_d = rd_cnt_q[ADDR_WIDTH-1:0];
        rd_cnt_d  = rd_cnt_q + CNT_ONE;
        idle_d    = '0;
        if (rd_cnt_q == LAST_C) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (wr_cnt_q == ROW_LEN_C) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (act_valid_out) begin
          idle_d = '0;
        end else begin
          idle_d = idle_q + IDLE_ONE;
          // Unit stopped answering: abort, keeping whatever was written.
          if (idle_d == TIMEOUT_C) begin
            err_d   = 1'b1;
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Collect path: counts actual results, so any unit latency works.
    if (result_ok_s) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wr_cnt_q[ADDR_WIDTH-1:0];
      wr_data_d = act_y;
      wr_cnt_d  = wr_cnt_q + CNT_ONE;
      if (act_oor) begin
        oor_d = oor_q + CNT_ONE;
      end else begin
        oor_d = oor_q;
      end
    end else begin
      wr_en_d = 1'b0;
    end
    // Results nobody asked for (idle, done, or past the row end) are dropped.
    err_d = err_d | (act_valid_out & ~result_ok_s);

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      idle_q      <= '0;
      oor_q       <= '0;
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      act_valid_q <= 1'b0;
      act_x_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      idle_q      <= idle_d;
      oor_q       <= oor_d;
      err_q       <= err_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      act_valid_q <= act_valid_d;
      act_x_q     <= act_x_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign src_rd_en   = rd_en_q;
  assign src_rd_addr = rd_addr_q;
  assign act_valid   = act_valid_q;
  assign act_x       = act_x_q;
  assign dst_wr_en   = wr_en_q;
  assign dst_wr_addr = wr_addr_q;
  assign dst_wr_data = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = err_q;
  assign oor_count   = oor_q;

endmodule
